relation_monitor: RTL and testbench

Streaming statistics and pattern monitor downstream of the 3-bit pair comparator. Each accepted sample is one set of comparator flags: gray, excess_3, more, less, no_relation. The block keeps saturating per-flag occurrence counts and a total count, and detects runs of consecutive gray-adjacent samples moving in one direction. Counts are read back through a one-cycle-latency read port; runs are signalled by a single-cycle pulse.

---
 rtl/relation_pkg.sv | 24 ++
 rtl/sat_counter.sv | 30 +++
 rtl/relation_monitor.sv | 170 +++++++++++++++++
 tb/tb_relation_monitor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/relation_pkg.sv
// Shared encodings for the relation monitor: read-select codes and run FSM states.
package relation_pkg;

  // Read-select codes; 6 and 7 are reserved and read back as zero.
  localparam logic [2:0] SEL_GRAY  = 3'd0;
  localparam logic [2:0] SEL_EX3   = 3'd1;
  localparam logic [2:0] SEL_MORE  = 3'd2;
  localparam logic [2:0] SEL_LESS  = 3'd3;
  localparam logic [2:0] SEL_NOREL = 3'd4;
  localparam logic [2:0] SEL_TOTAL = 3'd5;

  // Number of occurrence counters: five flags plus the total.
  localparam int N_CNT = 6;

  // Width of the run-length counter; RUN_LEN is limited to 15.
  localparam int LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] r_cnt;

  // Count up on inc until saturated; clear has priority over increment.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/relation_monitor.sv
// Comparator-flag statistics and gray-run detector with a registered read port.
module relation_monitor
  import relation_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_gray,
  input  logic             in_excess_3,
  input  logic             in_more,
  input  logic             in_less,
  input  logic             in_no_relation,
  input  logic             rd_req,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             run_hit,
  output logic             run_dir
);

  localparam logic [LEN_W-1:0] RUN_LEN_C = LEN_W'(RUN_LEN);

  logic             w_accept;
  logic [N_CNT-1:0] w_inc;
  logic [CNT_W-1:0] w_cnt [N_CNT];
  logic [CNT_W-1:0] w_rd_mux;
  logic             w_dir_gray;
  logic             w_same_dir;
  state_t           w_next_state;
  logic [LEN_W-1:0] w_next_len;
  logic             w_next_dir;
  logic             w_hit;

  state_t           r_state;
  logic [LEN_W-1:0] r_run_len;
  logic             r_run_dir;
  logic             r_run_hit;
  logic             r_rd_valid;
  logic [CNT_W-1:0] r_rd_data;

  // Clear blocks acceptance for that cycle; there is no other back-pressure.
  assign in_ready = ~clear;
  assign w_accept = in_valid & ~clear;

  // Bit order matches the SEL_* codes; the top bit is the total counter.
  assign w_inc = {1'b1, in_no_relation, in_less, in_more, in_excess_3, in_gray}
               & {N_CNT{w_accept}};

  for (genvar g = 0; g < N_CNT; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clear),
      .inc   (w_inc[g]),
      .cnt   (w_cnt[g])
    );
  end

  // Read mux over the pre-update counter values; reserved selects give zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_mux = '0;
    case (rd_sel)
      SEL_GRAY:  w_rd_mux = w_cnt[0];
      SEL_EX3:   w_rd_mux = w_cnt[1];
      SEL_MORE:  w_rd_mux = w_cnt[2];
      SEL_LESS:  w_rd_mux = w_cnt[3];
      SEL_NOREL: w_rd_mux = w_cnt[4];
      SEL_TOTAL: w_rd_mux = w_cnt[5];
      default:   w_rd_mux = '0;
    endcase
  end

  // A directional gray sample has the gray flag and exactly one direction flag.
  assign w_dir_gray = in_gray & (in_more ^ in_less);
  assign w_same_dir = w_dir_gray & (in_more == r_run_dir);

  // Run FSM next-state logic; only accepted samples move it.
  always_comb begin
    w_next_state = r_state;
    w_next_len   = r_run_len;
    w_next_dir   = r_run_dir;
    w_hit        = 1'b0;
    if (clear) begin
      w_next_state = ST_IDLE;
      w_next_len   = '0;
      w_next_dir   = 1'b0;
    end else if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_dir_gray) begin
            w_next_state = ST_RUN;
            w_next_len   = LEN_W'(1);
            w_next_dir   = in_more;
          end
        end
        ST_RUN: begin
          if (w_same_dir) begin
            w_next_len = r_run_len + 1'b1;
            if ((r_run_len + 1'b1) == RUN_LEN_C) begin
              w_hit        = 1'b1;
              w_next_state = ST_HIT;
            end
          end else if (w_dir_gray) begin
            w_next_len = LEN_W'(1);
            w_next_dir = in_more;
          end else begin
            w_next_state = ST_IDLE;
            w_next_len   = '0;
          end
        end
        ST_HIT: begin
          if (w_same_dir) begin
            w_next_state = ST_HIT;
          end else if (w_dir_gray) begin
            w_next_state = ST_RUN;
            w_next_len   = LEN_W'(1);
            w_next_dir   = in_more;
          end else begin
            w_next_state = ST_IDLE;
            w_next_len   = '0;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_len   = '0;
        end
      endcase
    end
  end

  // Run FSM state, run length, direction and hit pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run_len <= '0;
      r_run_dir <= 1'b0;
      r_run_hit <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_run_len <= w_next_len;
      r_run_dir <= w_next_dir;
      r_run_hit <= w_hit;
    end
  end

  // Read response: one-cycle valid pulse per request, data held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign run_hit  = r_run_hit;
  assign run_dir  = r_run_dir;

endmodule

// File: tb/tb_relation_monitor.sv
// Self-checking bench for relation_monitor: streak-based reference model plus directed vectors.
module tb_relation_monitor;

  localparam int CNT_W   = 8;
  localparam int RUN_LEN = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Flag vector bit order: {no_relation, less, more, excess_3, gray}.
  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_GRAY  = 5'b00001;
  localparam logic [4:0] F_MORE  = 5'b00100;
  localparam logic [4:0] F_LESS  = 5'b01000;
  localparam logic [4:0] F_NOREL = 5'b10000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       flags = '0;
  logic             rd_req = 1'b0;
  logic [2:0]       rd_sel = '0;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             run_hit;
  logic             run_dir;

  int n_checks = 0;
  int n_fail   = 0;

  relation_monitor #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_gray        (flags[0]),
    .in_excess_3    (flags[1]),
    .in_more        (flags[2]),
    .in_less        (flags[3]),
    .in_no_relation (flags[4]),
    .rd_req         (rd_req),
    .rd_sel         (rd_sel),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .run_hit        (run_hit),
    .run_dir        (run_dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts per flag, and a run is the length of the current
  // streak of same-direction directional gray samples; a hit is the streak
  // reaching exactly RUN_LEN.
  int   m_cnt [6];
  int   m_streak;
  logic m_dir;
  logic exp_hit;
  logic exp_valid;
  int   exp_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) m_cnt[i] = 0;
      m_streak  = 0;
      m_dir     = 1'b0;
      exp_hit   = 1'b0;
      exp_valid = 1'b0;
      exp_data  = 0;
    end else begin
      exp_valid = rd_req;
      if (rd_req) exp_data = (rd_sel < 3'd6) ? m_cnt[rd_sel] : 0;
      exp_hit = 1'b0;
      if (clear) begin
        for (int i = 0; i < 6; i++) m_cnt[i] = 0;
        m_streak = 0;
        m_dir    = 1'b0;
      end else if (in_valid) begin
        for (int i = 0; i < 5; i++)
          if (flags[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
        if (m_cnt[5] < CNT_MAX) m_cnt[5]++;
        if (flags[0] && (flags[2] != flags[3])) begin
          if (m_streak > 0 && flags[2] == m_dir) m_streak++;
          else m_streak = 1;
          m_dir = flags[2];
          if (m_streak == RUN_LEN) exp_hit = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, !clear);
      check("rd_valid", rd_valid, exp_valid);
      check("rd_data",  rd_data,  exp_data);
      check("run_hit",  run_hit,  exp_hit);
      check("run_dir",  run_dir,  m_dir);
    end
  end

  // One-cycle stimulus: drives after a falling edge, returns one cycle later
  // with inputs idle and the registered response visible.
  task automatic cycle(input logic v, input logic [4:0] f, input logic rq,
                       input logic [2:0] s, input logic clr);
    @(negedge clk); #2;
    in_valid = v; flags = f; rd_req = rq; rd_sel = s; clear = clr;
    @(negedge clk); #2;
    in_valid = 1'b0; flags = F_NONE; rd_req = 1'b0; rd_sel = '0; clear = 1'b0;
  endtask

  task automatic accept(input logic [4:0] f);
    cycle(1'b1, f, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic read_check(input logic [2:0] s, input int expv, input string name);
    cycle(1'b0, F_NONE, 1'b1, s, 1'b0);
    check({name, "_valid"}, rd_valid, 1);
    check(name, rd_data, expv);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data",  rd_data,  0);
    check("rst_run_hit",  run_hit,  0);
    check("rst_run_dir",  run_dir,  0);
    #2 rst_n = 1'b1;

    // All counters read zero after reset.
    for (int s = 0; s < 6; s++) read_check(3'(s), 0, "rd_zero");
    @(negedge clk); #1;
    check("rd_valid_one_cycle", rd_valid, 0);

    // Independent flag counting.
    accept(F_GRAY | F_MORE);
    accept(F_LESS);
    accept(F_NOREL);
    read_check(3'd0, 1, "cnt_gray");
    read_check(3'd1, 0, "cnt_ex3");
    read_check(3'd2, 1, "cnt_more");
    read_check(3'd3, 1, "cnt_less");
    read_check(3'd4, 1, "cnt_norel");
    read_check(3'd5, 3, "cnt_total");
    read_check(3'd6, 0, "cnt_reserved");

    // Back-to-back reads, then data hold.
    @(negedge clk); #2; rd_req = 1'b1; rd_sel = 3'd0;
    @(negedge clk); #2; rd_sel = 3'd5;
    check("b2b_first", rd_data, 1);
    @(negedge clk); #2; rd_req = 1'b0; rd_sel = 3'd0;
    check("b2b_second_valid", rd_valid, 1);
    check("b2b_second", rd_data, 3);
    @(negedge clk); #2;
    check("b2b_idle_valid", rd_valid, 0);
    check("b2b_hold", rd_data, 3);

    // Run of RUN_LEN same-direction gray samples.
    for (int i = 0; i < 3; i++) begin
      accept(F_GRAY | F_MORE);
      check("run_pre_hit", run_hit, 0);
    end
    accept(F_GRAY | F_MORE);
    check("run_hit_more", run_hit, 1);
    check("run_dir_more", run_dir, 1);
    @(negedge clk); #1;
    check("run_hit_pulse_end", run_hit, 0);
    accept(F_GRAY | F_MORE);
    check("run_no_rehit", run_hit, 0);

    // Direction changes restart the streak.
    for (int i = 0; i < 3; i++) begin
      accept(F_GRAY | F_MORE);
      check("mix_no_hit", run_hit, 0);
    end
    accept(F_GRAY | F_LESS);
    check("mix_dir_less", run_dir, 0);
    for (int i = 0; i < 3; i++) begin
      accept(F_GRAY | F_MORE);
      check("mix_no_hit", run_hit, 0);
    end
    for (int i = 0; i < 3; i++) begin
      accept(F_GRAY | F_LESS);
      check("less_no_hit", run_hit, 0);
    end
    accept(F_GRAY | F_LESS);
    check("run_hit_less", run_hit, 1);
    check("run_dir_less", run_dir, 0);

    // Saturation, then clear with a same-cycle read.
    for (int i = 0; i < 300; i++) accept(F_MORE);
    read_check(3'd2, 255, "sat_more");
    read_check(3'd5, 255, "sat_total");
    cycle(1'b1, F_MORE, 1'b1, 3'd2, 1'b1);
    check("clear_rd_pre", rd_data, 255);
    read_check(3'd2, 0, "clear_more");
    read_check(3'd5, 0, "clear_total");

    // Asynchronous reset mid-run with a read in flight.
    accept(F_GRAY | F_MORE);
    accept(F_GRAY | F_MORE);
    @(negedge clk); #2; rd_req = 1'b1; rd_sel = 3'd5;
    @(posedge clk); #1; rst_n = 1'b0; rd_req = 1'b0; rd_sel = '0;
    #1;
    check("arst_rd_valid", rd_valid, 0);
    check("arst_rd_data",  rd_data,  0);
    check("arst_run_hit",  run_hit,  0);
    check("arst_run_dir",  run_dir,  0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk); #2; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(F_GRAY | F_MORE);
      check("post_rst_no_hit", run_hit, 0);
    end
    accept(F_GRAY | F_MORE);
    check("post_rst_hit", run_hit, 1);
    read_check(3'd5, 4, "post_rst_total");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
